decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 234 +++++++++++++++++++++++
 tb/tb_decode_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Fetch-side instruction queue with an RV32I(M) decoder feeding a single
// registered dispatch slot towards the ROB/RS/LSB.
module decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned M_EXT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jp_wrong,
  input  logic        ins_flag,
  input  logic [31:0] ins,
  input  logic        jp_flag,
  input  logic [31:0] jp_pc,
  output logic        stall_IF,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [5:0]  insty,
  output logic [31:0] imm,
  output logic        to_LSB,
  output logic        to_RS,
  output logic        illegal,
  output logic        jp_flag_o,
  output logic [31:0] jp_pc_o
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [6:0] OpLui = 7'd55, OpAuipc = 7'd23, OpJal = 7'd111, OpJalr = 7'd103;
  localparam logic [6:0] OpBranch = 7'd99, OpLoad = 7'd3, OpStore = 7'd35;
  localparam logic [6:0] OpImm = 7'd19, OpReg = 7'd51;

  localparam logic [5:0] InstLui = 6'd0, InstAuipc = 6'd1, InstJal = 6'd2, InstJalr = 6'd3;
  localparam logic [5:0] InstBeq = 6'd4, InstBlt = 6'd6, InstLb = 6'd10, InstLbu = 6'd13;
  localparam logic [5:0] InstSb = 6'd15, InstAddi = 6'd18, InstSlti = 6'd19, InstSltiu = 6'd20;
  localparam logic [5:0] InstXori = 6'd21, InstOri = 6'd22, InstAndi = 6'd23, InstSlli = 6'd24;
  localparam logic [5:0] InstSrli = 6'd25, InstSrai = 6'd26, InstAdd = 6'd27, InstSub = 6'd28;
  localparam logic [5:0] InstSll = 6'd29, InstSlt = 6'd30, InstSltu = 6'd31, InstXor = 6'd32;
  localparam logic [5:0] InstOr = 6'd33, InstAnd = 6'd34, InstSrl = 6'd35, InstSra = 6'd36;
  localparam logic [5:0] InstMul = 6'd37, InstNop = 6'd63;

  typedef struct packed {
    logic [31:0] ins;
    logic        jpf;
    logic [31:0] jpc;
  } entry_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [5:0]  insty;
    logic [31:0] imm;
    logic        to_lsb;
    logic        to_rs;
    logic        illegal;
    logic        jpf;
    logic [31:0] jpc;
  } dec_t;

  localparam dec_t RstOut = {5'd0, 5'd0, 5'd0, InstNop, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            out_valid_q, out_valid_d;
  dec_t            out_q, out_d, dec;
  logic            full, empty, push, pop, ill;
  entry_t          hd;
  logic [31:0]     hi;
  logic [2:0]      f3;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = ins_flag & rdy & ~jp_wrong & ~full;
  // The entry enqueued this edge is never visible here, so there is no bypass.
  assign pop   = rdy & ~jp_wrong & ~empty & (~out_valid_q | out_ready);

  assign hd = mem_q[head_q];
  assign hi = hd.ins;
  assign f3 = hi[14:12];

  always_comb begin
    ill           = 1'b0;
    dec           = RstOut;
    dec.rd        = hi[11:7];
    dec.rs1       = hi[19:15];
    dec.jpf       = hd.jpf;
    dec.jpc       = hd.jpc;
    unique case (hi[6:0])
      OpLui, OpAuipc: begin
        dec.rs1   = '0;
        dec.imm   = {hi[31:12], 12'h000};
        dec.insty = (hi[6:0] == OpLui) ? InstLui : InstAuipc;
      end
      OpJal: begin
        dec.rs1   = '0;
        dec.imm   = {{11{hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
        dec.insty = InstJal;
      end
      OpJalr: begin
        dec.imm   = {{20{hi[31]}}, hi[31:20]};
        dec.to_rs = 1'b1;
        dec.insty = InstJalr;
      end
      OpBranch: begin
        dec.rd    = '0;
        dec.rs2   = hi[24:20];
        dec.imm   = {{19{hi[31]}}, hi[31], hi[7], hi[30:25], hi[11:8], 1'b0};
        dec.to_rs = 1'b1;
        if (f3[2])       dec.insty = InstBlt + {4'b0, f3[1:0]};
        else if (!f3[1]) dec.insty = InstBeq + {5'b0, f3[0]};
        else             ill = 1'b1;
      end
      OpLoad: begin
        dec.imm    = {{20{hi[31]}}, hi[31:20]};
        dec.to_lsb = 1'b1;
        if (f3 <= 3'd2)                  dec.insty = InstLb + {3'b0, f3};
        else if (f3 == 3'd4 || f3 == 3'd5) dec.insty = InstLbu + {5'b0, f3[0]};
        else                             ill = 1'b1;
      end
      OpStore: begin
        dec.rd     = '0;
        dec.rs2    = hi[24:20];
        dec.imm    = {{20{hi[31]}}, hi[31:25], hi[11:7]};
        dec.to_lsb = 1'b1;
        if (f3 <= 3'd2) dec.insty = InstSb + {3'b0, f3};
        else            ill = 1'b1;
      end
      OpImm: begin
        dec.to_rs = 1'b1;
        dec.imm   = {{20{hi[31]}}, hi[31:20]};
        unique case (f3)
          3'd0: dec.insty = InstAddi;
          3'd2: dec.insty = InstSlti;
          3'd3: dec.insty = InstSltiu;
          3'd4: dec.insty = InstXori;
          3'd6: dec.insty = InstOri;
          3'd7: dec.insty = InstAndi;
          default: begin
            dec.imm   = {27'd0, hi[24:20]};
            dec.insty = (f3 == 3'd1) ? InstSlli : (hi[30] ? InstSrai : InstSrli);
          end
        endcase
      end
      OpReg: begin
        dec.rs2   = hi[24:20];
        dec.to_rs = 1'b1;
        if (hi[31:25] == 7'b0000001) begin
          if (M_EXT != 0) dec.insty = InstMul + {3'b0, f3};
          else            ill = 1'b1;
        end else begin
          unique case (f3)
            3'd0: dec.insty = hi[30] ? InstSub : InstAdd;
            3'd1: dec.insty = InstSll;
            3'd2: dec.insty = InstSlt;
            3'd3: dec.insty = InstSltu;
            3'd4: dec.insty = InstXor;
            3'd5: dec.insty = hi[30] ? InstSra : InstSrl;
            3'd6: dec.insty = InstOr;
            default: dec.insty = InstAnd;
          endcase
        end
      end
      default: ill = 1'b1;
    endcase
    // Illegal instructions still dispatch, but as a routing-free NOP.
    if (ill) begin
      dec.illegal = 1'b1;
      dec.insty   = InstNop;
      dec.to_lsb  = 1'b0;
      dec.to_rs   = 1'b0;
      dec.rd      = '0;
    end
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_d       = pop ? dec : out_q;
    if (jp_wrong) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) tail_d = tail_q + PtrW'(1);
      if (pop)  head_d = head_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
      if (pop)                               out_valid_d = 1'b1;
      else if (out_valid_q && out_ready && rdy) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= RstOut;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{ins: ins, jpf: jp_flag, jpc: jp_pc};
  end

  assign stall_IF  = full;
  assign out_valid = out_valid_q;
  assign rd        = out_q.rd;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign insty     = out_q.insty;
  assign imm       = out_q.imm;
  assign to_LSB    = out_q.to_lsb;
  assign to_RS     = out_q.to_rs;
  assign illegal   = out_q.illegal;
  assign jp_flag_o = out_q.jpf;
  assign jp_pc_o   = out_q.jpc;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: a queue-level model plus a mask/match opcode table
// checks two instances (with and without the M extension) every cycle.
module tb_decode_queue;
  localparam int unsigned DEPTH = 4;

  logic        clk, rst, rdy, jp_wrong, ins_flag, jp_flag, out_ready;
  logic [31:0] ins, jp_pc;

  logic        v_m, st_m, lsb_m, rsf_m, ill_m, jf_m;
  logic [4:0]  rd_m, rs1_m, rs2_m;
  logic [5:0]  ty_m;
  logic [31:0] imm_m, jpc_m;
  logic        v_b, st_b, lsb_b, rsf_b, ill_b, jf_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [5:0]  ty_b;
  logic [31:0] imm_b, jpc_b;

  decode_queue #(.DEPTH(DEPTH), .M_EXT(1)) u_dut_m (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong), .ins_flag(ins_flag), .ins(ins),
    .jp_flag(jp_flag), .jp_pc(jp_pc), .stall_IF(st_m), .out_ready(out_ready),
    .out_valid(v_m), .rd(rd_m), .rs1(rs1_m), .rs2(rs2_m), .insty(ty_m), .imm(imm_m),
    .to_LSB(lsb_m), .to_RS(rsf_m), .illegal(ill_m), .jp_flag_o(jf_m), .jp_pc_o(jpc_m)
  );

  decode_queue #(.DEPTH(DEPTH), .M_EXT(0)) u_dut_b (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong), .ins_flag(ins_flag), .ins(ins),
    .jp_flag(jp_flag), .jp_pc(jp_pc), .stall_IF(st_b), .out_ready(out_ready),
    .out_valid(v_b), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b), .insty(ty_b), .imm(imm_b),
    .to_LSB(lsb_b), .to_RS(rsf_b), .illegal(ill_b), .jp_flag_o(jf_b), .jp_pc_o(jpc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic        jpf;
    logic [31:0] jpc;
  } ent_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          ty;
    bit          mx;
  } pat_t;

  typedef struct packed {
    logic [4:0]  rd, rs1, rs2;
    logic [5:0]  ty;
    logic [31:0] imm;
    logic        lsb, rsf, ill;
  } mdec_t;

  pat_t        pats[$];
  ent_t        mq[$];
  ent_t        mo;
  bit          mv = 1'b0;
  bit          m_take;
  int          checks = 0, errors = 0, disp_cnt = 0;
  logic [31:0] last_imm = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic ap(input logic [31:0] mask, input logic [31:0] match, input int ty,
                    input bit mx = 1'b0);
    pats.push_back('{mask, match, ty, mx});
  endtask

  // Opcode/funct table in the style of the ISA manual's encoding listings.
  initial begin
    ap('h7F, 'h37, 0); ap('h7F, 'h17, 1); ap('h7F, 'h6F, 2); ap('h7F, 'h67, 3);
    ap('h707F, 'h63, 4); ap('h707F, 'h1063, 5); ap('h707F, 'h4063, 6);
    ap('h707F, 'h5063, 7); ap('h707F, 'h6063, 8); ap('h707F, 'h7063, 9);
    ap('h707F, 'h03, 10); ap('h707F, 'h1003, 11); ap('h707F, 'h2003, 12);
    ap('h707F, 'h4003, 13); ap('h707F, 'h5003, 14);
    ap('h707F, 'h23, 15); ap('h707F, 'h1023, 16); ap('h707F, 'h2023, 17);
    ap('h707F, 'h13, 18); ap('h707F, 'h2013, 19); ap('h707F, 'h3013, 20);
    ap('h707F, 'h4013, 21); ap('h707F, 'h6013, 22); ap('h707F, 'h7013, 23);
    ap('hFE00707F, 'h1013, 24); ap('hFE00707F, 'h5013, 25); ap('hFE00707F, 'h40005013, 26);
    ap('hFE00707F, 'h33, 27); ap('hFE00707F, 'h40000033, 28); ap('hFE00707F, 'h1033, 29);
    ap('hFE00707F, 'h2033, 30); ap('hFE00707F, 'h3033, 31); ap('hFE00707F, 'h4033, 32);
    ap('hFE00707F, 'h6033, 33); ap('hFE00707F, 'h7033, 34); ap('hFE00707F, 'h5033, 35);
    ap('hFE00707F, 'h40005033, 36);
    for (int f = 0; f < 8; f++) ap('hFE00707F, 32'h02000033 | (f << 12), 37 + f, 1'b1);
  end

  function automatic mdec_t model_dec(input logic [31:0] i, input bit mx);
    mdec_t d;
    int    ty;
    int    op;
    ty = -1;
    op = int'(i[6:0]);
    foreach (pats[k])
      if (ty < 0 && (i & pats[k].mask) == pats[k].match && (mx || !pats[k].mx)) ty = pats[k].ty;
    d.ill = (ty < 0);
    d.ty  = d.ill ? 6'd63 : 6'(ty);
    d.rd  = (d.ill || op == 99 || op == 35) ? 5'd0 : i[11:7];
    d.rs1 = (op == 111 || op == 55 || op == 23) ? 5'd0 : i[19:15];
    d.rs2 = (op == 99 || op == 35 || op == 51) ? i[24:20] : 5'd0;
    case (op)
      3, 103:  d.imm = {{20{i[31]}}, i[31:20]};
      19:      d.imm = (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? {27'd0, i[24:20]}
                                                             : {{20{i[31]}}, i[31:20]};
      35:      d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      99:      d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      111:     d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      55, 23:  d.imm = {i[31:12], 12'd0};
      default: d.imm = 32'd0;
    endcase
    d.lsb = !d.ill && (op == 3 || op == 35);
    d.rsf = !d.ill && (op == 19 || op == 51 || op == 99 || op == 103);
    return d;
  endfunction

  // Transaction-level queue model: a FIFO of fetched entries plus one held slot.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst || jp_wrong) begin
      mq.delete();
      mv = 1'b0;
    end else if (rdy) begin
      m_take = ins_flag && (mq.size() < DEPTH);
      if (mq.size() > 0 && (!mv || out_ready)) begin
        mo = mq.pop_front();
        mv = 1'b1;
      end else if (mv && out_ready) begin
        mv = 1'b0;
      end
      if (m_take) mq.push_back('{ins, jp_flag, jp_pc});
    end
  end

  task automatic cmp(input string t, input bit mx, input logic v, input logic st,
                     input logic [4:0] a_rd, input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                     input logic [5:0] a_ty, input logic [31:0] a_imm, input logic a_lsb,
                     input logic a_rsf, input logic a_ill, input logic a_jf,
                     input logic [31:0] a_jpc);
    mdec_t d;
    chk({t, ".out_valid"}, 32'(v), 32'(mv));
    chk({t, ".stall_IF"}, 32'(st), 32'(mq.size() == DEPTH));
    if (mv) begin
      d = model_dec(mo.ins, mx);
      chk({t, ".rd"}, 32'(a_rd), 32'(d.rd));
      chk({t, ".rs1"}, 32'(a_rs1), 32'(d.rs1));
      chk({t, ".rs2"}, 32'(a_rs2), 32'(d.rs2));
      chk({t, ".insty"}, 32'(a_ty), 32'(d.ty));
      chk({t, ".imm"}, a_imm, d.imm);
      chk({t, ".to_LSB"}, 32'(a_lsb), 32'(d.lsb));
      chk({t, ".to_RS"}, 32'(a_rsf), 32'(d.rsf));
      chk({t, ".illegal"}, 32'(a_ill), 32'(d.ill));
      chk({t, ".jp_flag_o"}, 32'(a_jf), 32'(mo.jpf));
      chk({t, ".jp_pc_o"}, a_jpc, mo.jpc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      cmp("m", 1'b1, v_m, st_m, rd_m, rs1_m, rs2_m, ty_m, imm_m, lsb_m, rsf_m, ill_m, jf_m, jpc_m);
      cmp("b", 1'b0, v_b, st_b, rd_b, rs1_b, rs2_b, ty_b, imm_b, lsb_b, rsf_b, ill_b, jf_b, jpc_b);
      if (v_m && out_ready && rdy && !jp_wrong) begin
        disp_cnt++;
        last_imm = imm_m;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] i, input logic jf, input logic [31:0] pc);
    ins_flag = 1'b1;
    ins      = i;
    jp_flag  = jf;
    jp_pc    = pc;
    tick();
    ins_flag = 1'b0;
  endtask

  function automatic logic [31:0] addi(input int k);
    return (32'(k) << 20) | 32'h0000_0093;
  endfunction

  logic [31:0] vecs [16];
  int          base, tries;
  bit          acc;

  initial begin
    vecs = '{32'h02208033, 32'hFE000EE3, 32'h0040A103, 32'h0020A223, 32'h123450B7,
             32'h00001117, 32'h008000EF, 32'h000080E7, 32'h4030D093, 32'h40208133,
             32'hFFFFFFFF, 32'h0000A063, 32'h0000B023, 32'h00109093, 32'h0220C1B3,
             32'hFFC14083};
    rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0; ins_flag = 1'b0; ins = '0;
    jp_flag = 1'b0; jp_pc = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst.out_valid", 32'(v_m), 0);
    chk("rst.insty", 32'(ty_m), 63);
    chk("rst.stall_IF", 32'(st_m), 0);
    chk("rst.imm", imm_m, 0);
    rst = 1'b0;

    // Minimum latency: fetch at edge 1, visible after edge 2.
    fetch(32'h00500093, 1'b0, 32'h0);
    chk("lat.edge1_valid", 32'(v_m), 0);
    tick();
    chk("addi.valid", 32'(v_m), 1);
    chk("addi.insty", 32'(ty_m), 18);
    chk("addi.rd", 32'(rd_m), 1);
    chk("addi.rs1", 32'(rs1_m), 0);
    chk("addi.rs2", 32'(rs2_m), 0);
    chk("addi.imm", imm_m, 5);
    chk("addi.to_RS", 32'(rsf_m), 1);
    tick();

    fetch(32'h02208033, 1'b0, 32'h0);
    tick();
    chk("mul.m_insty", 32'(ty_m), 37);
    chk("mul.m_illegal", 32'(ill_m), 0);
    chk("mul.b_insty", 32'(ty_b), 63);
    chk("mul.b_illegal", 32'(ill_b), 1);
    tick();

    fetch(32'hFE000EE3, 1'b1, 32'h1000);
    tick();
    chk("beq.rd", 32'(rd_m), 0);
    chk("beq.rs2", 32'(rs2_m), 0);
    chk("beq.imm", imm_m, 32'hFFFF_FFFC);
    chk("beq.jp_pc_o", jpc_m, 32'h1000);
    chk("beq.jp_flag_o", 32'(jf_m), 1);
    tick();

    // Mixed stream with rdy and out_ready stalls; each fetch retried until taken.
    for (int k = 0; k < 16; k++) begin
      ins_flag = 1'b1; ins = vecs[k]; jp_flag = k[0]; jp_pc = 32'h2000 + 32'(k * 4);
      tries = 0;
      do begin
        rdy = ((k + tries) % 5 != 3);
        out_ready = ((k + tries) % 3 != 1);
        acc = rdy && !st_m;
        tick();
        tries++;
      end while (!acc && tries < 20);
    end
    ins_flag = 1'b0; rdy = 1'b1; out_ready = 1'b1;
    repeat (DEPTH + 3) tick();

    // Fill to full with the output slot held, then drain.
    out_ready = 1'b0;
    base = disp_cnt;
    for (int k = 1; k <= DEPTH; k++) fetch(addi(k), 1'b0, 32'h0);
    chk("fill.not_yet_full", 32'(st_m), 0);
    fetch(addi(DEPTH + 1), 1'b0, 32'h0);
    chk("fill.stall_IF", 32'(st_m), 1);
    chk("fill.held_imm", imm_m, 1);
    fetch(addi(DEPTH + 2), 1'b0, 32'h0);
    chk("fill.still_full", 32'(st_m), 1);
    out_ready = 1'b1;
    repeat (DEPTH + 3) tick();
    chk("drain.count", 32'(disp_cnt - base), 32'(DEPTH + 1));
    chk("drain.last_imm", last_imm, 32'(DEPTH + 1));

    // Flush overrides rdy=0 and a concurrent fetch.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) fetch(addi(10 + k), 1'b0, 32'h0);
    rdy = 1'b0; jp_wrong = 1'b1; ins_flag = 1'b1; ins = addi(20);
    tick();
    chk("flush.out_valid", 32'(v_m), 0);
    chk("flush.stall_IF", 32'(st_m), 0);
    jp_wrong = 1'b0; rdy = 1'b1; ins_flag = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("flush.empty_after", 32'(v_m), 0);

    // Asynchronous reset between edges with entries queued.
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) fetch(addi(30 + k), 1'b1, 32'h3000);
    rst = 1'b1;
    #1;
    chk("arst.out_valid", 32'(v_m), 0);
    chk("arst.insty", 32'(ty_m), 63);
    chk("arst.imm", imm_m, 0);
    chk("arst.jp_pc_o", jpc_m, 0);
    chk("arst.jp_flag_o", 32'(jf_m), 0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("arst.no_stale", 32'(v_m), 0);
    fetch(addi(7), 1'b0, 32'h0);
    tick();
    chk("arst.resume_valid", 32'(v_m), 1);
    chk("arst.resume_imm", imm_m, 7);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
